// File: rtl/logistic_sched_if.sv
// logistic_sched_if: control/update bus between the logistic sequencer and the oscillator bank
interface logistic_sched_if #(
  parameter int FRAC = 16,
  parameter int IW   = 3
);
  logic            en;
  logic            busy;
  logic            upd_valid;
  logic [IW-1:0]   upd_idx;
  logic [FRAC-1:0] upd_x;
  logic [FRAC+1:0] r_out;
  logic            overrun;
  modport master (input en, output busy, upd_valid, upd_idx, upd_x, r_out, overrun);
  modport slave  (output en, input busy, upd_valid, upd_idx, upd_x, r_out, overrun);
endinterface

// File: rtl/logistic_sched.sv
// logistic_sched: time-shared logistic-map iterator publishing new x values to the oscillator bank
module logistic_sched #(
  parameter int N_OSC    = 8,
  parameter int ITER_LEN = 15361,
  parameter int R_INC    = 2,
  parameter int FRAC     = 16,
  parameter int R_MIN    = 3 << FRAC,
  parameter int R_MAX    = (4 << FRAC) - 1
) (
  input logic               clk,
  input logic               rst_n,
  logistic_sched_if.master  bus
);
  localparam int IW = (N_OSC > 1) ? $clog2(N_OSC) : 1;
  localparam int CW = $clog2(ITER_LEN);
  typedef enum logic [1:0] {IDLE, MUL1, MUL2} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FRAC-1:0]   x_q [N_OSC];
  logic [FRAC-1:0]   x_d [N_OSC];
  logic [FRAC-1:0]   t_q, t_d;
  logic [FRAC+1:0]   r_q, r_d;
  logic              upd_valid_q, upd_valid_d;
  logic [IW-1:0]     upd_idx_q, upd_idx_d;
  logic [FRAC-1:0]   upd_x_q, upd_x_d;
  logic              overrun_q, overrun_d;
  logic              launch;
  logic [FRAC-1:0]   x_cur;
  logic [FRAC+1:0]   mul_a;
  logic [FRAC-1:0]   mul_b;
  logic [2*FRAC+1:0] prod;
  logic [FRAC+1:0]   prod_hi;
  logic [FRAC-1:0]   p;
  logic [FRAC+2:0]   r_sum;
  logic [FRAC+1:0]   r_next;
  logic              unused_lo;
  assign launch    = bus.en && (cnt_q == CW'(ITER_LEN - 1));
  assign x_cur     = x_q[idx_q];
  // One shared multiplier: x*(1-x) in MUL1 (one's complement keeps 1-x in FRAC bits), r*t in MUL2
  assign mul_a     = (state_q == MUL1) ? {2'b00, x_cur} : r_q;
  assign mul_b     = (state_q == MUL1) ? ~x_cur : t_q;
  assign prod      = mul_a * mul_b;
  assign prod_hi   = prod[2*FRAC+1:FRAC];
  assign unused_lo = ^prod[FRAC-1:0];
  assign p         = (|prod_hi[FRAC+1:FRAC]) ? '1 : prod_hi[FRAC-1:0];
  assign r_sum     = {1'b0, r_q} + (FRAC+3)'(R_INC);
  assign r_next    = (r_sum > (FRAC+3)'(R_MAX)) ? (FRAC+2)'(R_MIN) : r_sum[FRAC+1:0];
  assign bus.busy      = state_q != IDLE;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_idx   = upd_idx_q;
  assign bus.upd_x     = upd_x_q;
  assign bus.r_out     = r_q;
  assign bus.overrun   = overrun_q;
  // Next-state: interval counter, sweep FSM, x/r write-back and update strobe
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    t_d         = t_q;
    r_d         = r_q;
    x_d         = x_q;
    upd_valid_d = 1'b0;
    upd_idx_d   = upd_idx_q;
    upd_x_d     = upd_x_q;
    cnt_d       = bus.en ? (launch ? '0 : cnt_q + 1'b1) : cnt_q;
    overrun_d   = overrun_q | (launch && state_q != IDLE);
    case (state_q)
      IDLE: if (launch) begin
        state_d = MUL1;
        idx_d   = '0;
      end
      MUL1: begin
        t_d     = prod_hi[FRAC-1:0];
        state_d = MUL2;
      end
      MUL2: begin
        x_d[idx_q]  = p;
        upd_valid_d = 1'b1;
        upd_idx_d   = idx_q;
        upd_x_d     = p;
        state_d     = (idx_q == IW'(N_OSC - 1)) ? IDLE : MUL1;
        idx_d       = (idx_q == IW'(N_OSC - 1)) ? idx_q : idx_q + 1'b1;
        r_d         = (idx_q == IW'(N_OSC - 1)) ? r_next : r_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // State registers; reset reseeds x with evenly spaced fractions (i+1)/(N_OSC+1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      t_q         <= '0;
      r_q         <= (FRAC+2)'(R_MIN);
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_x_q     <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N_OSC; i++) x_q[i] <= FRAC'(((i + 1) << FRAC) / (N_OSC + 1));
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      t_q         <= t_d;
      r_q         <= r_d;
      x_q         <= x_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_x_q     <= upd_x_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_logistic_sched.sv
// tb_logistic_sched: random-enable run against a sweep-level reference model, plus overrun/wrap scenario
module tb_logistic_sched;
  localparam int NA = 2;
  logic clk = 1'b0;
  logic rst_n_a, rst_n_b;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;

  logistic_sched_if #(.FRAC(8), .IW(1)) bus_a ();
  logistic_sched_if #(.FRAC(8), .IW(1)) bus_b ();

  logistic_sched #(.N_OSC(NA), .ITER_LEN(10), .R_INC(2), .FRAC(8), .R_MIN(768), .R_MAX(1023))
    dut_a (.clk(clk), .rst_n(rst_n_a), .bus(bus_a));
  logistic_sched #(.N_OSC(NA), .ITER_LEN(3), .R_INC(2), .FRAC(8), .R_MIN(1020), .R_MAX(1023))
    dut_b (.clk(clk), .rst_n(rst_n_b), .bus(bus_b));

  // reference model state for dut_a: sweep-level view (phase since launch, precomputed results)
  int m_cnt, m_ph, m_r, m_idx, m_xo;
  int m_x [NA];
  int m_nx [NA];
  logic m_valid, m_ovr;

  function automatic int f(input int r, input int x);
    int t, p;
    t = (x * (255 - x)) >> 8;
    p = (r * t) >> 8;
    return (p > 255) ? 255 : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ph = 0; m_r = 768; m_idx = 0; m_xo = 0;
    m_valid = 1'b0; m_ovr = 1'b0;
    for (int i = 0; i < NA; i++) m_x[i] = ((i + 1) * 256) / (NA + 1);
  endtask

  task automatic step(input logic e);
    logic was_busy, launch;
    int j;
    bus_a.en = e;
    @(posedge clk); #1;
    was_busy = m_ph != 0;
    launch = e && m_cnt == 9;
    m_cnt = e ? (launch ? 0 : m_cnt + 1) : m_cnt;
    m_valid = 1'b0;
    if (was_busy) begin
      if (launch) m_ovr = 1'b1;
      m_ph++;
      if (m_ph % 2 == 1) begin
        j = (m_ph - 3) / 2;
        m_valid = 1'b1; m_idx = j; m_xo = m_nx[j]; m_x[j] = m_nx[j];
      end
      if (m_ph == 2 * NA + 1) begin
        m_r = (m_r + 2 > 1023) ? 768 : m_r + 2;
        m_ph = 0;
      end
    end else if (launch) begin
      m_ph = 1;
      for (int i = 0; i < NA; i++) m_nx[i] = f(m_r, m_x[i]);
    end
    chk("a_upd_valid", bus_a.upd_valid, m_valid);
    chk("a_upd_idx", bus_a.upd_idx, m_idx);
    chk("a_upd_x", bus_a.upd_x, m_xo);
    chk("a_r_out", bus_a.r_out, m_r);
    chk("a_busy", bus_a.busy, m_ph != 0);
    chk("a_overrun", bus_a.overrun, m_ovr);
  endtask

  task automatic reset_a();
    rst_n_a = 1'b0;
    bus_a.en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("a_rst_busy", bus_a.busy, 0);
    chk("a_rst_valid", bus_a.upd_valid, 0);
    chk("a_rst_idx", bus_a.upd_idx, 0);
    chk("a_rst_x", bus_a.upd_x, 0);
    chk("a_rst_r", bus_a.r_out, 768);
    chk("a_rst_ovr", bus_a.overrun, 0);
    model_reset();
    rst_n_a = 1'b1;
  endtask

  initial begin
    int c;
    int bx0, bx1;
    rst_n_b = 1'b0;
    bus_b.en = 1'b0;
    // scenario 1: free-running after reset, first sweep at cycle 9
    reset_a();
    for (int i = 0; i < 30; i++) step(1'b1);
    // scenario 2: en held low for 20 cycles, then running
    reset_a();
    for (int i = 0; i < 20; i++) step(1'b0);
    for (int i = 0; i < 25; i++) step(1'b1);
    // scenario 5: asynchronous reset while in MUL2
    reset_a();
    for (int i = 0; i < 30 && m_ph != 2; i++) step(1'b1);
    chk("a_reached_mul2", bus_a.busy, 1);
    rst_n_a = 1'b0;
    #1;
    chk("a_async_valid", bus_a.upd_valid, 0);
    chk("a_async_busy", bus_a.busy, 0);
    chk("a_async_r", bus_a.r_out, 768);
    model_reset();
    #2;
    rst_n_a = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1);
    // random enable run long enough to walk r through its wrap
    for (int i = 0; i < 4000; i++) step(1'(($urandom_range(0, 3)) != 0));
    // scenario 3/4: short interval forces overrun; r steps 1020 -> 1022 -> wrap to R_MIN
    bus_a.en = 1'b0;
    #1;
    rst_n_b = 1'b1;
    bus_b.en = 1'b1;
    bx0 = f(1020, 85);
    bx1 = f(1020, 170);
    for (c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      chk("b_busy", bus_b.busy, (c >= 3 && c <= 6) || (c >= 9 && c <= 12) || c >= 15);
      chk("b_overrun", bus_b.overrun, c >= 6);
      chk("b_r_out", bus_b.r_out, (c < 7) ? 1020 : (c < 13) ? 1022 : 1020);
      chk("b_upd_valid", bus_b.upd_valid, c == 5 || c == 7 || c == 11 || c == 13);
      if (c == 5 || c == 7 || c == 11 || c == 13) begin
        chk("b_upd_idx", bus_b.upd_idx, (c == 5 || c == 11) ? 0 : 1);
        chk("b_upd_x", bus_b.upd_x, (c == 5) ? bx0 : (c == 7) ? bx1 :
                                    (c == 11) ? f(1022, bx0) : f(1022, bx1));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
